pl_adc_burst_ctrl: RTL and testbench
====================================

// Module: pl_adc_burst_ctrl
// PURPOSE
//  Sequencer for the PL CMOS ADC capture block: runs a programmed number of capture bursts of i_Samples words each,
//  with a fixed idle gap between bursts. It drives the capture block's work/count/done-clean handshake and checks its
//  done flag. Sits between the PS-side control registers (AXI-lite regfile) and the capture block, in the i_CMOS_Clk domain.
// PARAMETERS
//  COUNT_W      32   width of samples-per-burst (matches capture block i_Count)
//  BURST_W      16   width of burst count / burst index
//  GAP_W        16   width of inter-burst gap counter
//  TMO_MARGIN   64   cycles allowed beyond i_Samples before a burst is declared timed out
// PORTS
//  i_CMOS_Clk   in   1        clock; all logic on rising edge
//  i_Rst_n      in   1        reset, synchronous, active-low
//  i_Start      in   1        1-cycle pulse: latch config, begin sequence (ignored while o_Busy)
//  i_Abort      in   1        level/pulse: stop sequence at next safe point
//  i_Samples    in   COUNT_W  samples per burst, latched on accepted i_Start
//  i_Bursts     in   BURST_W  bursts per sequence, latched; 0 = continuous until abort
//  i_Gap        in   GAP_W    idle cycles between bursts, latched
//  i_ADC_Done   in   1        capture block done flag (level, sticky until cleaned)
//  o_ADC_Work   out  1        capture block work request
//  o_Count      out  COUNT_W  capture block sample count (latched i_Samples)
//  o_Done_Clean out  1        capture block done-flag clear
//  o_Busy       out  1        sequence in progress (state != IDLE)
//  o_Burst_Idx  out  BURST_W  bursts completed in current sequence
//  o_Seq_Done   out  1        1-cycle pulse: sequence finished normally or aborted
//  o_Cfg_Err    out  1        1-cycle pulse: i_Start rejected (i_Samples < 2)
//  o_Timeout    out  1        sticky: a burst exceeded i_Samples+TMO_MARGIN; cleared by next accepted i_Start
// BEHAVIOUR
//  Reset (i_Rst_n==0 at edge): state IDLE; all outputs 0, incl. o_Count, o_Burst_Idx, o_Timeout. Reset mid-burst
//   drops o_ADC_Work immediately; the capture block's stale done flag is handled by FLUSH on the next start.
//  States: IDLE, FLUSH, RUN, CLEAN, GAP.
//  IDLE: on i_Start: if i_Samples<2 -> o_Cfg_Err pulse, stay IDLE; else latch config, o_Burst_Idx=0,
//   o_Timeout=0, -> FLUSH.
//  FLUSH: if i_ADC_Done==1 assert o_Done_Clean, hold until i_ADC_Done==0; then -> RUN (min 1 cycle in FLUSH).
//  RUN: o_ADC_Work=1, timeout counter counts from 0. On i_ADC_Done==1: o_ADC_Work=0 and o_Done_Clean=1 on the
//   same edge (work and clean never high together), o_Burst_Idx++, -> CLEAN.
//   If counter reaches i_Samples+TMO_MARGIN: set o_Timeout, o_ADC_Work=0, -> CLEAN (no index increment).
//  CLEAN: hold o_Done_Clean until i_ADC_Done==0 sampled, then deassert. Next state:
//   abort pending or o_Timeout -> IDLE with o_Seq_Done pulse;
//   i_Bursts!=0 and o_Burst_Idx==i_Bursts -> IDLE with o_Seq_Done pulse;
//   else i_Gap==0 -> RUN; else -> GAP.
//  GAP: count i_Gap cycles (exactly i_Gap cycles in GAP), then -> RUN. Abort in GAP -> IDLE, o_Seq_Done pulse.
//  Abort: i_Abort sets a pending flag in any non-IDLE state. RUN finishes the current burst (no truncation);
//   FLUSH/GAP exit at once. The flag clears on IDLE entry. Abort in IDLE is ignored.
//  Simultaneous i_Start+i_Abort in IDLE: start accepted, abort ignored.
//  o_Burst_Idx wraps modulo 2^BURST_W in continuous mode. Timeout sum is computed at COUNT_W+1 bits (no wrap).
//  o_Count is stable for the whole sequence; changes only on accepted i_Start. All outputs are registered.
//  Latency: i_Start -> o_ADC_Work = 2 cycles when i_ADC_Done==0.
// STRUCTURE
//  Shared package pl_adc_pkg: state encoding localparams (ST_IDLE..ST_GAP), COUNT_W/BURST_W defaults, TMO_MARGIN.
//  One sub-module: pl_down_counter (load/enable/zero flag), used for the gap timer and the timeout timer.
//  The FSM, the config latch and the burst index are kept in this module.
// TESTING (bench includes a behavioural model of the capture block: done after i_Count cycles, cleared by clean)
//  Start Samples=16,Bursts=3,Gap=5 -> 3 work pulses; 5-cycle gaps; o_Burst_Idx 1,2,3; one o_Seq_Done; o_Timeout=0.
//  Start Samples=1 -> o_Cfg_Err pulse, o_Busy stays 0, o_ADC_Work never asserted.
//  Bursts=0,Gap=0 continuous; abort mid-burst 4 -> burst 4 completes, o_Burst_Idx=4, o_Seq_Done, IDLE.
//  Model never raises done, Samples=100 -> o_Timeout after 164 RUN cycles, work drops, o_Seq_Done, IDLE.
//  Done stuck high before start -> FLUSH drives clean until done=0 before the first o_ADC_Work.
//  i_Rst_n low in RUN -> next edge all outputs 0; restart succeeds; assert work&&clean never true.

Source files
------------

// File: rtl/pl_adc_pkg.sv
// Shared types and defaults for the PL CMOS ADC burst sequencer.
// State encoding, default widths and the burst timeout margin.
package pl_adc_pkg;

  localparam int COUNT_W_DFLT    = 32;
  localparam int BURST_W_DFLT    = 16;
  localparam int GAP_W_DFLT      = 16;
  localparam int TMO_MARGIN_DFLT = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CLEAN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FLUSH = ST_FLUSH,
    S_RUN   = ST_RUN,
    S_CLEAN = ST_CLEAN,
    S_GAP   = ST_GAP
  } state_e;

endpackage

// File: rtl/pl_adc_burst_ctrl_if.sv
// Capture-block handshake: work/count/done-clean out, done flag in.
// master = sequencer side, slave = capture block side.
interface pl_adc_burst_ctrl_if #(
  parameter int COUNT_W = 32
);
  logic               ADC_Work;
  logic [COUNT_W-1:0] Count;
  logic               Done_Clean;
  logic               ADC_Done;

  modport master (
    output ADC_Work, Count, Done_Clean,
    input  ADC_Done
  );

  modport slave (
    input  ADC_Work, Count, Done_Clean,
    output ADC_Done
  );
endinterface

// File: rtl/pl_down_counter.sv
// Loadable down counter with zero flag; load wins over enable.
// Ports: clk_i, rst_ni (sync), load_i/val_i, en_i, zero_o.
module pl_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pl_adc_burst_ctrl.sv
// Burst sequencer for the PL CMOS ADC capture block.
// Ports: clk/rst, start/abort + config in, cap handshake, status out.
module pl_adc_burst_ctrl
  import pl_adc_pkg::*;
#(
  parameter int COUNT_W    = COUNT_W_DFLT,
  parameter int BURST_W    = BURST_W_DFLT,
  parameter int GAP_W      = GAP_W_DFLT,
  parameter int TMO_MARGIN = TMO_MARGIN_DFLT
) (
  input  logic               i_CMOS_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  input  logic               i_Abort,
  input  logic [COUNT_W-1:0] i_Samples,
  input  logic [BURST_W-1:0] i_Bursts,
  input  logic [GAP_W-1:0]   i_Gap,
  pl_adc_burst_ctrl_if.master cap,
  output logic               o_Busy,
  output logic [BURST_W-1:0] o_Burst_Idx,
  output logic               o_Seq_Done,
  output logic               o_Cfg_Err,
  output logic               o_Timeout
);

  localparam int TW = COUNT_W + 1;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BURST_W-1:0] idx_q, idx_d;
  logic               abort_q, abort_d;
  logic               work_q, work_d;
  logic               clean_q, clean_d;
  logic               busy_q, busy_d;
  logic               sdone_q, sdone_d;
  logic               cfg_q, cfg_d;
  logic               tmo_q, tmo_d;

  logic               tmo_load, tmo_en, tmo_zero;
  logic               gap_load, gap_en, gap_zero;
  logic [TW-1:0]      tmo_val;
  logic [GAP_W-1:0]   gap_val;
  logic               abort_hit;

  // Loaded with limit-1 so zero is seen on the limit-th RUN cycle.
  assign tmo_val   = {1'b0, count_q} + TW'(TMO_MARGIN - 1);
  assign gap_val   = gap_q - 1'b1;
  assign abort_hit = abort_q | i_Abort;

  pl_down_counter #(.W(TW)) u_tmo (
    .clk_i  (i_CMOS_Clk),
    .rst_ni (i_Rst_n),
    .load_i (tmo_load),
    .val_i  (tmo_val),
    .en_i   (tmo_en),
    .zero_o (tmo_zero)
  );

  pl_down_counter #(.W(GAP_W)) u_gap (
    .clk_i  (i_CMOS_Clk),
    .rst_ni (i_Rst_n),
    .load_i (gap_load),
    .val_i  (gap_val),
    .en_i   (gap_en),
    .zero_o (gap_zero)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    bursts_d = bursts_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    work_d   = 1'b0;
    clean_d  = 1'b0;
    sdone_d  = 1'b0;
    cfg_d    = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          if (i_Samples < COUNT_W'(2)) begin
            cfg_d = 1'b1;
          end else begin
            count_d  = i_Samples;
            bursts_d = i_Bursts;
            gap_d    = i_Gap;
            idx_d    = '0;
            tmo_d    = 1'b0;
            state_d  = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (abort_hit) begin
          sdone_d = 1'b1;
          state_d = S_IDLE;
        end else if (cap.ADC_Done) begin
          clean_d = 1'b1;
        end else begin
          work_d   = 1'b1;
          tmo_load = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // A finished burst wins over a coincident timeout.
        if (cap.ADC_Done) begin
          clean_d = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_CLEAN;
        end else if (tmo_zero) begin
          tmo_d   = 1'b1;
          state_d = S_CLEAN;
        end else begin
          work_d = 1'b1;
          tmo_en = 1'b1;
        end
      end
      S_CLEAN: begin
        if (cap.ADC_Done) begin
          clean_d = 1'b1;
        end else if (abort_hit || tmo_q) begin
          sdone_d = 1'b1;
          state_d = S_IDLE;
        end else if (bursts_q != '0 && idx_q == bursts_q) begin
          sdone_d = 1'b1;
          state_d = S_IDLE;
        end else if (gap_q == '0) begin
          work_d   = 1'b1;
          tmo_load = 1'b1;
          state_d  = S_RUN;
        end else begin
          gap_load = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (abort_hit) begin
          sdone_d = 1'b1;
          state_d = S_IDLE;
        end else if (gap_zero) begin
          work_d   = 1'b1;
          tmo_load = 1'b1;
          state_d  = S_RUN;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    abort_d = (state_d == S_IDLE) ? 1'b0 :
              (abort_q | (i_Abort && state_q != S_IDLE));
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge i_CMOS_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      bursts_q <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      abort_q  <= 1'b0;
      work_q   <= 1'b0;
      clean_q  <= 1'b0;
      busy_q   <= 1'b0;
      sdone_q  <= 1'b0;
      cfg_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bursts_q <= bursts_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      abort_q  <= abort_d;
      work_q   <= work_d;
      clean_q  <= clean_d;
      busy_q   <= busy_d;
      sdone_q  <= sdone_d;
      cfg_q    <= cfg_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cap.ADC_Work   = work_q;
  assign cap.Count      = count_q;
  assign cap.Done_Clean = clean_q;
  assign o_Busy         = busy_q;
  assign o_Burst_Idx    = idx_q;
  assign o_Seq_Done     = sdone_q;
  assign o_Cfg_Err      = cfg_q;
  assign o_Timeout      = tmo_q;

endmodule

// File: tb/tb_pl_adc_burst_ctrl.sv
// Bench for pl_adc_burst_ctrl with a behavioural capture block.
// Scenario tasks compare against expectations from burst/gap rules.
module tb_pl_adc_burst_ctrl;

  localparam int CW     = 32;
  localparam int BW     = 16;
  localparam int GW     = 16;
  localparam int MARGIN = 64;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic [CW-1:0] samples = '0;
  logic [BW-1:0] bursts  = '0;
  logic [GW-1:0] gap     = '0;
  logic          busy, sdone, cfg_err, tmo;
  logic [BW-1:0] idx;

  int n_tests = 0;
  int n_fail  = 0;

  pl_adc_burst_ctrl_if #(.COUNT_W(CW)) cap_if ();

  pl_adc_burst_ctrl #(
    .COUNT_W(CW), .BURST_W(BW), .GAP_W(GW), .TMO_MARGIN(MARGIN)
  ) dut (
    .i_CMOS_Clk (clk),
    .i_Rst_n    (rst_n),
    .i_Start    (start),
    .i_Abort    (abort),
    .i_Samples  (samples),
    .i_Bursts   (bursts),
    .i_Gap      (gap),
    .cap        (cap_if),
    .o_Busy     (busy),
    .o_Burst_Idx(idx),
    .o_Seq_Done (sdone),
    .o_Cfg_Err  (cfg_err),
    .o_Timeout  (tmo)
  );

  always #5 clk = ~clk;

  // Capture block: raises done after Count work cycles, clean clears it.
  logic        done_m     = 1'b0;
  logic        never_done = 1'b0;
  logic        set_done   = 1'b0;
  int unsigned wcnt       = 0;

  always @(posedge clk) begin
    if (set_done) begin
      done_m <= 1'b1;
    end else if (cap_if.Done_Clean) begin
      done_m <= 1'b0;
      wcnt   <= 0;
    end else if (cap_if.ADC_Work) begin
      if (!done_m && !never_done) begin
        wcnt <= wcnt + 1;
        if (wcnt + 1 >= cap_if.Count) done_m <= 1'b1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  assign cap_if.ADC_Done = done_m;

  // Observation: work pulses, quiet cycles before each pulse, run lengths.
  int n_rise = 0, n_sdone = 0, n_overlap = 0, quiet = 0, run_len = 0;
  logic prev_w = 1'b0;
  logic [BW-1:0] last_idx = '0;
  int gaps[$];
  int runs[$];
  int idxs[$];

  always @(negedge clk) begin
    if (cap_if.ADC_Work && cap_if.Done_Clean) n_overlap++;
    if (sdone) n_sdone++;
    if (cap_if.ADC_Work && !prev_w) begin
      n_rise++;
      gaps.push_back(quiet);
      quiet   = 0;
      run_len = 0;
    end
    if (!cap_if.ADC_Work && prev_w) runs.push_back(run_len);
    if (cap_if.ADC_Work) run_len++;
    else if (busy && !cap_if.Done_Clean) quiet++;
    if (!busy) quiet = 0;
    if (idx != last_idx && idx != '0) idxs.push_back(int'(idx));
    last_idx = idx;
    prev_w   = cap_if.ADC_Work;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_rise  = 0;
    n_sdone = 0;
    gaps.delete();
    runs.delete();
    idxs.delete();
  endtask

  task automatic pulse_start(input int s, input int b, input int g);
    samples = CW'(s);
    bursts  = BW'(b);
    gap     = GW'(g);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_seq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sdone) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if ({cap_if.ADC_Work, cap_if.Done_Clean, busy, sdone, cfg_err, tmo} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {cap_if.ADC_Work, cap_if.Done_Clean, busy, sdone, cfg_err, tmo});
    end
    n_tests++;
    if (cap_if.Count !== '0 || idx !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: count %0d idx %0d want 0 0", cap_if.Count, idx);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    pulse_start(16, 3, 5);
    n_tests++;
    if (busy !== 1'b1 || cap_if.ADC_Work !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_lat1: busy %b work %b want 1 0", busy, cap_if.ADC_Work);
    end
    step();
    n_tests++;
    if (cap_if.ADC_Work !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_lat2: work %b want 1", cap_if.ADC_Work);
    end
    step();
    samples = CW'(99);
    start   = 1'b1;
    step();
    start   = 1'b0;
    step();
    n_tests++;
    if (cap_if.Count !== CW'(16)) begin
      n_fail++;
      $display("FAIL basic_busy_start: count %0d want 16", cap_if.Count);
    end
    wait_seq(2000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_seq_done: got none want pulse");
    end
    n_tests++;
    if (n_rise !== 3 || n_sdone !== 1) begin
      n_fail++;
      $display("FAIL basic_counts: pulses %0d done %0d want 3 1", n_rise, n_sdone);
    end
    n_tests++;
    if (idxs.size() !== 3 || idxs[0] !== 1 || idxs[1] !== 2 || idxs[2] !== 3) begin
      n_fail++;
      $display("FAIL basic_idx_seq: got %p want 1 2 3", idxs);
    end
    n_tests++;
    if (gaps.size() !== 3 || gaps[1] !== 5 || gaps[2] !== 5) begin
      n_fail++;
      $display("FAIL basic_gaps: got %p want [x,5,5]", gaps);
    end
    n_tests++;
    if (tmo !== 1'b0 || busy !== 1'b0 || idx !== BW'(3)) begin
      n_fail++;
      $display("FAIL basic_end: tmo %b busy %b idx %0d want 0 0 3", tmo, busy, idx);
    end
  endtask

  task automatic test_cfg_err();
    for (int v = 0; v < 2; v++) begin
      clear_mon();
      pulse_start(v, 2, 1);
      n_tests++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err_%0d: err %b busy %b want 1 0", v, cfg_err, busy);
      end
      for (int i = 0; i < 20; i++) step();
      n_tests++;
      if (n_rise !== 0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_quiet_%0d: pulses %0d busy %b err %b want 0 0 0",
                 v, n_rise, busy, cfg_err);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      int s = int'($urandom_range(24, 2));
      int b = int'($urandom_range(4, 1));
      int g = int'($urandom_range(6, 0));
      bit gaps_ok = 1'b1;
      clear_mon();
      pulse_start(s, b, g);
      wait_seq(3000, ok);
      for (int i = 1; i < gaps.size(); i++)
        if (gaps[i] != g) gaps_ok = 1'b0;
      n_tests++;
      if (!ok || n_rise !== b || idx !== BW'(b) || n_sdone !== 1) begin
        n_fail++;
        $display("FAIL rand_%0d: ok %0d pulses %0d idx %0d done %0d want 1 %0d %0d 1",
                 it, ok, n_rise, idx, n_sdone, b, b);
      end
      n_tests++;
      if (!gaps_ok || gaps.size() !== b || cap_if.Count !== CW'(s) || tmo !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_gap_%0d: gaps %p count %0d tmo %b want gap %0d count %0d tmo 0",
                 it, gaps, cap_if.Count, tmo, g, s);
      end
    end
  endtask

  task automatic test_abort_cont();
    bit ok;
    bit gaps_ok = 1'b1;
    int s = int'($urandom_range(20, 6));
    int k = int'($urandom_range(5, 2));
    clear_mon();
    pulse_start(s, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      if (n_rise >= k) break;
      step();
    end
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_seq(2000, ok);
    for (int i = 1; i < gaps.size(); i++)
      if (gaps[i] != 0) gaps_ok = 1'b0;
    n_tests++;
    if (!ok || n_rise !== k || idx !== BW'(k) || n_sdone !== 1) begin
      n_fail++;
      $display("FAIL abort_cont: ok %0d pulses %0d idx %0d done %0d want 1 %0d %0d 1",
               ok, n_rise, idx, n_sdone, k, k);
    end
    n_tests++;
    if (!gaps_ok || busy !== 1'b0 || runs.size() !== k || runs[k-1] < s) begin
      n_fail++;
      $display("FAIL abort_full_burst: runs %p busy %b want %0d runs >= %0d, idle",
               runs, busy, k, s);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    never_done = 1'b1;
    clear_mon();
    pulse_start(100, 2, 0);
    wait_seq(1000, ok);
    n_tests++;
    if (!ok || runs.size() !== 1 || runs[0] !== 100 + MARGIN) begin
      n_fail++;
      $display("FAIL tmo_run_len: ok %0d runs %p want [%0d]", ok, runs, 100 + MARGIN);
    end
    n_tests++;
    if (tmo !== 1'b1 || idx !== '0 || busy !== 1'b0 || n_sdone !== 1) begin
      n_fail++;
      $display("FAIL tmo_status: tmo %b idx %0d busy %b done %0d want 1 0 0 1",
               tmo, idx, busy, n_sdone);
    end
    never_done = 1'b0;
    clear_mon();
    pulse_start(8, 1, 0);
    n_tests++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: tmo %b want 0", tmo);
    end
    wait_seq(500, ok);
    n_tests++;
    if (!ok || idx !== BW'(1) || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_restart: ok %0d idx %0d tmo %b want 1 1 0", ok, idx, tmo);
    end
  endtask

  task automatic test_flush();
    bit ok;
    int n_clean = 0;
    set_done = 1'b1;
    step();
    set_done = 1'b0;
    step();
    clear_mon();
    pulse_start(8, 1, 0);
    for (int i = 0; i < 50; i++) begin
      if (cap_if.ADC_Work) break;
      if (cap_if.Done_Clean) n_clean++;
      step();
    end
    n_tests++;
    if (n_clean < 1 || cap_if.ADC_Work !== 1'b1 || done_m !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clean: cleans %0d work %b done %b want >=1 1 0",
               n_clean, cap_if.ADC_Work, done_m);
    end
    wait_seq(500, ok);
    n_tests++;
    if (!ok || idx !== BW'(1) || n_rise !== 1) begin
      n_fail++;
      $display("FAIL flush_seq: ok %0d idx %0d pulses %0d want 1 1 1", ok, idx, n_rise);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_mon();
    pulse_start(30, 2, 3);
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({cap_if.ADC_Work, cap_if.Done_Clean, busy, sdone, cfg_err, tmo} !== 6'b0
        || cap_if.Count !== '0 || idx !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: flags %b count %0d idx %0d want 0 0 0",
               {cap_if.ADC_Work, cap_if.Done_Clean, busy, sdone, cfg_err, tmo},
               cap_if.Count, idx);
    end
    rst_n = 1'b1;
    step();
    clear_mon();
    pulse_start(10, 1, 0);
    wait_seq(500, ok);
    n_tests++;
    if (!ok || idx !== BW'(1) || n_rise !== 1) begin
      n_fail++;
      $display("FAIL rst_restart: ok %0d idx %0d pulses %0d want 1 1 1", ok, idx, n_rise);
    end
  endtask

  task automatic test_overlap();
    n_tests++;
    if (n_overlap !== 0) begin
      n_fail++;
      $display("FAIL work_clean_overlap: got %0d cycles want 0", n_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_err();
    test_random();
    test_abort_cont();
    test_timeout();
    test_flush();
    test_rst_mid();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
